// File: rtl/rr_arb_pkg.sv
// Shared types and elaboration helpers for the round-robin decode arbiter.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int ceil_log2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot select vector; out-of-range indices decode to zero.
// Purely combinational, no backpressure.
module onehot_decoder #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            en,
    input  logic [IDXW-1:0] idx,
    output logic [N-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        if (en && ({1'b0, idx} < (IDXW+1)'(N)))
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter with hold timeout, one-hot grant for a shared datapath.
// Latency: 1 cycle req->gnt; backpressure: none, requesters hold req until granted.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int CNTW = (MAX_HOLD < 1) ? 1 : ceil_log2(MAX_HOLD + 1);
    localparam logic [CNTW-1:0] HOLD_SAT  = CNTW'(MAX_HOLD);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(N - 1);

    if (IDXW != ceil_log2(N) || N < 2 || N > 16) begin : g_param_check
        $error("rr_decode_arbiter: IDXW must equal ceil(log2(N)) and N must be 2..16");
    end

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [CNTW-1:0] hold_cnt;

    logic            sel_found;
    logic [IDXW-1:0] sel_idx;
    logic [IDXW-1:0] ptr_next;
    logic            others_waiting;
    logic            rel_norm;
    logic            rel_tmo;

    // Wrapping scan starting at ptr; candidate index is reduced mod N explicitly
    // so non-power-of-two N never probes a non-existent requester.
    always_comb begin
        int c;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!sel_found && req[c]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(c);
            end
        end
    end

    assign ptr_next       = (gnt_idx == IDX_MAX) ? '0 : gnt_idx + 1'b1;
    assign others_waiting = |(req & ~gnt);
    assign rel_norm       = done || !req[gnt_idx];
    assign rel_tmo        = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others_waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        gnt_idx   <= sel_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != HOLD_SAT)
                        hold_cnt <= hold_cnt + 1'b1;
                    // A normal release wins over a coincident timeout.
                    if (rel_norm || rel_tmo) begin
                        ptr       <= ptr_next;
                        gnt_valid <= 1'b0;
                        timeout   <= !rel_norm;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    onehot_decoder #(
        .N    (N),
        .IDXW (IDXW)
    ) u_gnt_dec (
        .en     (gnt_valid),
        .idx    (gnt_idx),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_decode_arbiter #(
        .N        (4),
        .IDXW     (2),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant invariants and bus turnaround, sampled mid-cycle.
    logic [3:0] prev_gnt = '0;
    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("gnt_vs_valid", 32'((gnt != 4'b0) == gnt_valid), 32'd1);
        check("turnaround", 32'(prev_gnt != 4'b0 && gnt != 4'b0 && prev_gnt != gnt), 32'd0);
        prev_gnt = gnt;
    end

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_ptr", 32'(dut.ptr), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req", 32'(gnt_valid), 32'h0);

        // Rotation with all requesting, done one cycle after each grant
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rot_gnt", 32'(gnt), 32'(1 << exp_seq[i]));
            check("rot_idx", 32'(gnt_idx), 32'(exp_seq[i]));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rot_idle", 32'(gnt), 32'h0);
        end
        check("rot_ptr", 32'(dut.ptr), 32'd1);

        // Wrap and skip
        req = 4'b1000;
        tick();
        check("wrap_g3", 32'(gnt), 32'h8);
        req = 4'b0101;
        tick();
        check("wrap_rel", 32'(gnt_valid), 32'h0);
        check("wrap_ptr", 32'(dut.ptr), 32'd0);
        tick();
        check("wrap_g0", 32'(gnt), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("skip_g2", 32'(gnt), 32'h4);

        // Requester drop
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0010;
        tick();
        check("drop_g1", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check("drop_valid", 32'(gnt_valid), 32'h0);
        check("drop_ptr", 32'(dut.ptr), 32'd2);
        check("drop_tmo", 32'(timeout), 32'h0);

        // Timeout: idx 0 holds for exactly 8 cycles while idx 1 waits
        req = 4'b0011;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("tmo_hold", 32'(gnt), 32'h1);
            check("tmo_quiet", 32'(timeout), 32'h0);
            tick();
        end
        check("tmo_rel", 32'(gnt), 32'h0);
        check("tmo_pulse", 32'(timeout), 32'h1);
        tick();
        check("tmo_next", 32'(gnt), 32'h2);
        check("tmo_once", 32'(timeout), 32'h0);

        // Sole requester keeps the grant past MAX_HOLD
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0001;
        tick();
        for (int i = 0; i < 12; i++) begin
            check("sole_hold", 32'(gnt), 32'h1);
            check("sole_tmo", 32'(timeout), 32'h0);
            tick();
        end

        // Coincident done and timeout condition
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0011;
        tick();
        check("coin_g1", 32'(gnt), 32'h2);
        for (int i = 0; i < 7; i++) tick();
        check("coin_still", 32'(gnt), 32'h2);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("coin_rel", 32'(gnt_valid), 32'h0);
        check("coin_tmo", 32'(timeout), 32'h0);
        check("coin_ptr", 32'(dut.ptr), 32'd2);

        // Reset mid-grant clears outputs before the next edge
        req = 4'b0010;
        tick();
        check("mrst_g1", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_gnt", 32'(gnt), 32'h0);
        check("mrst_valid", 32'(gnt_valid), 32'h0);
        check("mrst_idx", 32'(gnt_idx), 32'h0);
        check("mrst_ptr", 32'(dut.ptr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_first", 32'(gnt_idx), 32'd1);
        check("mrst_first_gnt", 32'(gnt), 32'h2);

        req = 4'b0000;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one decoded resource between N requesters.
- Selects one requester, holds the grant until that requester releases it or a hold timeout fires, then rotates priority.
- Drives the grant as a binary index plus its one-hot decode.
- The one-hot output feeds the select lines of the shared datapath.

Parameters:
- N, 4, number of requesters (2..16).
- IDXW, 2, width of the grant index; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester waits; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request, level-sensitive.
- done  input  1  release pulse from the current grantee.
- gnt  output  N  one-hot grant, all zero when idle.
- gnt_idx  output  IDXW  binary index of the grantee; holds its last value when idle.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset: asynchronous on the falling edge of rst_n. While rst_n is low, all of these hold:
  - state = IDLE
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0
  - rotation pointer ptr = 0
  - hold counter = 0
- Reset mid-grant drops gnt immediately, with no release cycle.
- FSM states are IDLE and GRANT.
- IDLE:
  - If req != 0, choose the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrapping).
  - Register that index into gnt_idx, set gnt_valid = 1, clear the hold counter, go to GRANT.
  - Grant latency is 1 cycle: req seen at edge k gives gnt at edge k+1.
  - If req == 0, stay in IDLE.
- GRANT:
  - Hold counter increments each cycle, saturating at MAX_HOLD.
  - Release occurs when any of the following holds:
    - (a) done = 1;
    - (b) req[gnt_idx] = 0 (requester dropped);
    - (c) MAX_HOLD != 0, counter == MAX_HOLD-1 and any other req bit is set.
  - On release: ptr <= (gnt_idx+1) mod N, go to IDLE, gnt_valid <= 0.
  - Case (c) pulses timeout for exactly one cycle, coincident with gnt_valid falling.
  - If (a)/(b) and (c) coincide, timeout is not asserted; a normal release has priority.
- Bus turnaround: every release is followed by exactly one IDLE cycle with gnt = 0. This guarantees no two grants are ever active in the same or adjacent cycles.
- Pointer wrap: ptr arithmetic is modulo N. The pointer never holds a value >= N, including when N is not a power of 2.
- done while in IDLE is ignored.
- req bits that change during GRANT do not affect the current grant, except as release condition (b) or as the "other waiting" input to (c).
- gnt is the combinational one-hot decode of the registered gnt_idx, gated by the registered gnt_valid, so it is glitch-free.
- Invariant: $onehot0(gnt) always holds. gnt != 0 if and only if gnt_valid = 1.
- Sole requester with MAX_HOLD reached and no other waiting: the grant continues indefinitely.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding constants ST_IDLE = 1'b0, ST_GRANT = 1'b1;
  - a function computing ceil(log2) for IDXW sanity checks.
- One sub-module: onehot_decoder (parameters N, IDXW).
  - Inputs: en, idx. Output: N-bit one-hot vector.
  - Output is all-zero when en = 0 or idx >= N.
  - Instantiated once to produce gnt from gnt_valid/gnt_idx.
- Round-robin selection and the FSM stay in rr_decode_arbiter.

Test Plan:
- Reset: assert rst_n = 0 mid-grant with req = 4'b0010. Outputs must be 0 in the same cycle, before the next clk edge. After deassertion, the first grant goes to index 1 (ptr = 0, scan from 0).
- Rotation: req = 4'b1111 held, done pulsed one cycle after each grant. Grant sequence must be idx 0, 1, 2, 3, 0, with one idle cycle between each. Latency from first req to gnt = 4'b0001 is 1 cycle.
- Wrap and skip: after a grant to idx 3, req = 4'b0101. Next grant must be idx 0; after done, the next grant must be idx 2.
- Requester drop: granted idx 1 deasserts req[1] with done = 0. gnt_valid must fall on the next edge and ptr must become 2.
- Timeout: MAX_HOLD = 8, req = 4'b0011, idx 0 never pulses done. The grant lasts exactly 8 cycles, then timeout pulses once, then after one idle cycle gnt = 4'b0010. With req = 4'b0001 only, the grant persists beyond 8 cycles and timeout stays 0.
- Coincident release: done = 1 in the same cycle the timeout condition is met. Timeout must stay 0 and ptr must advance normally.
